// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding and default
// device addresses for the two-master bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] RD_ADDR_DEF = 16'hFFF0;
    localparam logic [15:0] WR_ADDR_DEF = 16'hFFF8;

    // Keep the wait-state count inside what the 4-bit counter can express.
    function automatic logic [3:0] clamp_wait(input int n);
        if (n < 1) return 4'd1;
        if (n > 15) return 4'd15;
        return 4'(n);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes
// to the master that was not granted last.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last;

    // Pick the winner; a tie goes away from the last-granted master.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember who won; starts as master 1 so master 0 takes the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            last <= 1'b1;
        else if (update && (|gnt))
            last <= gnt[1];
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus with round-robin grant,
// address decode, fixed wait states and ack/err completion.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] RD_ADDR     = RD_ADDR_DEF,
    parameter logic [15:0] WR_ADDR     = WR_ADDR_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        w0,
    input  logic        w1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic [15:0] dbus_in,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] abus,
    output logic        w,
    output logic [15:0] dbus_out,
    output logic        dbus_oe,
    output logic        rd_sel,
    output logic        wd_sel
);

    localparam logic [3:0] WC = clamp_wait(WAIT_CYCLES);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  arb_gnt;
    logic [1:0]  owner;
    logic [15:0] abus_r;
    logic [15:0] wdata_r;
    logic [15:0] rdata_r;
    logic        w_r;
    logic [3:0]  cnt;
    logic        grant;
    logic        last_wait;

    rr_arb2 u_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({req1, req0}),
        .update  (grant),
        .gnt     (arb_gnt)
    );

    assign grant     = (state == IDLE) && (|arb_gnt);
    assign last_wait = (state == WAIT) && (cnt == 4'd1);
    assign abus      = abus_r;
    assign w         = w_r;
    assign rdata     = rdata_r;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state plus grant, decode, data drive and completion outputs.
    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        ack      = 1'b0;
        err      = 1'b0;
        rd_sel   = 1'b0;
        wd_sel   = 1'b0;
        dbus_oe  = 1'b0;
        dbus_out = 16'h0000;
        case (state)
            IDLE:    if (grant) state_nx = ADDR;
            ADDR:    state_nx = WAIT;
            WAIT:    if (last_wait) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state != IDLE) begin
            gnt0     = owner[0];
            gnt1     = owner[1];
            rd_sel   = !w_r && (abus_r == RD_ADDR);
            wd_sel   = w_r && (abus_r == WR_ADDR);
            dbus_oe  = w_r;
            dbus_out = w_r ? wdata_r : 16'h0000;
        end
        if (state == DONE) begin
            ack = 1'b1;
            err = !(rd_sel || wd_sel);
        end
    end

    // Latch the winner's request at grant, count wait states, capture reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner   <= 2'b00;
            abus_r  <= 16'h0000;
            w_r     <= 1'b0;
            wdata_r <= 16'h0000;
            rdata_r <= 16'h0000;
            cnt     <= 4'd0;
        end else begin
            if (grant) begin
                owner   <= arb_gnt;
                abus_r  <= arb_gnt[1] ? addr1 : addr0;
                w_r     <= arb_gnt[1] ? w1 : w0;
                wdata_r <= arb_gnt[1] ? wdata1 : wdata0;
            end
            case (state)
                ADDR:    cnt <= WC;
                WAIT:    cnt <= cnt - 4'd1;
                default: cnt <= 4'd0;
            endcase
            if (last_wait && rd_sel)
                rdata_r <= dbus_in;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random transactions on two
// bus_arbiter instances (1 and 3 wait states) vs a txn-level model.
module tb_bus_arbiter;

    localparam logic [15:0] RD_A = 16'hFFF0;
    localparam logic [15:0] WR_A = 16'hFFF8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        req0, req1, w0, w1;
    logic [15:0] addr0, addr1, wdata0, wdata1, dbus_in;

    logic        a_gnt0, a_gnt1, a_ack, a_err, a_w, a_oe, a_rs, a_ws;
    logic [15:0] a_rdata, a_abus, a_dout;
    logic        b_gnt0, b_gnt1, b_ack, b_err, b_w, b_oe, b_rs, b_ws;
    logic [15:0] b_rdata, b_abus, b_dout;

    logic        o_gnt0, o_gnt1, o_ack, o_err, o_w, o_oe, o_rs, o_ws;
    logic [15:0] o_rdata, o_abus, o_dout;

    bit dsel;
    int wc;
    int n_cmp = 0;
    int n_bad = 0;
    int last_m;
    logic [15:0] rdata_m;

    bus_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .w0(w0), .w1(w1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .dbus_in(dbus_in),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .ack(a_ack), .err(a_err),
        .rdata(a_rdata), .abus(a_abus), .w(a_w),
        .dbus_out(a_dout), .dbus_oe(a_oe),
        .rd_sel(a_rs), .wd_sel(a_ws)
    );

    bus_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .w0(w0), .w1(w1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .dbus_in(dbus_in),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .ack(b_ack), .err(b_err),
        .rdata(b_rdata), .abus(b_abus), .w(b_w),
        .dbus_out(b_dout), .dbus_oe(b_oe),
        .rd_sel(b_rs), .wd_sel(b_ws)
    );

    always_comb begin
        o_gnt0 = a_gnt0; o_gnt1 = a_gnt1;
        o_ack = a_ack; o_err = a_err; o_w = a_w;
        o_oe = a_oe; o_rs = a_rs; o_ws = a_ws;
        o_rdata = a_rdata; o_abus = a_abus; o_dout = a_dout;
        if (dsel) begin
            o_gnt0 = b_gnt0; o_gnt1 = b_gnt1;
            o_ack = b_ack; o_err = b_err; o_w = b_w;
            o_oe = b_oe; o_rs = b_rs; o_ws = b_ws;
            o_rdata = b_rdata; o_abus = b_abus; o_dout = b_dout;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".gnt"}, 32'({o_gnt1, o_gnt0}), 32'd0);
        check({tag, ".ack"}, 32'(o_ack), 32'd0);
        check({tag, ".err"}, 32'(o_err), 32'd0);
        check({tag, ".oe"}, 32'(o_oe), 32'd0);
        check({tag, ".sel"}, 32'({o_rs, o_ws}), 32'd0);
        check({tag, ".rdata"}, 32'(o_rdata), 32'(rdata_m));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".gnt"}, 32'({o_gnt1, o_gnt0}), 32'd0);
        check({tag, ".ack_err"}, 32'({o_ack, o_err}), 32'd0);
        check({tag, ".abus"}, 32'(o_abus), 32'd0);
        check({tag, ".w"}, 32'(o_w), 32'd0);
        check({tag, ".dbus"}, 32'({o_oe, o_dout}), 32'd0);
        check({tag, ".sel"}, 32'({o_rs, o_ws}), 32'd0);
        check({tag, ".rdata"}, 32'(o_rdata), 32'd0);
    endtask

    // Round-robin rule: sole requester wins, a tie goes to
    // whoever was not served last. -1 means nobody requests.
    function automatic int pick(input logic r0, input logic r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (r0 && r1) return (last_m == 1) ? 0 : 1;
        return -1;
    endfunction

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return RD_A;
            1:       return WR_A;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Entered at the falling edge of an idle cycle. Drives one request
    // set and follows the expected transaction through to completion.
    task automatic txn(input logic r0, input logic r1,
                       input logic wv0, input logic wv1,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] din, input bit scr);
        int win;
        logic [15:0] ea, ed;
        logic ew, rs, ws;
        check_idle("idle");
        req0 = r0; req1 = r1; w0 = wv0; w1 = wv1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        dbus_in = 16'($urandom);
        win = pick(r0, r1);
        ea = (win == 1) ? a1 : a0;
        ew = (win == 1) ? wv1 : wv0;
        ed = (win == 1) ? d1 : d0;
        rs = !ew && (ea == RD_A);
        ws = ew && (ea == WR_A);
        @(negedge clock);
        if (win < 0) begin
            check_idle("noreq");
            return;
        end
        last_m = win;
        for (int k = 0; k <= wc + 1; k++) begin
            check("gnt", 32'({o_gnt1, o_gnt0}),
                  (win == 1) ? 32'd2 : 32'd1);
            check("abus", 32'(o_abus), 32'(ea));
            check("w", 32'(o_w), 32'(ew));
            check("rd_sel", 32'(o_rs), 32'(rs));
            check("wd_sel", 32'(o_ws), 32'(ws));
            check("dbus_oe", 32'(o_oe), 32'(ew));
            check("dbus_out", 32'(o_dout), ew ? 32'(ed) : 32'd0);
            check("ack", 32'(o_ack), 32'(k == wc + 1));
            check("rdata", 32'(o_rdata), 32'(rdata_m));
            if (k == wc + 1)
                check("err", 32'(o_err), 32'(!(rs || ws)));
            if (scr) begin
                req0 = 1'($urandom); req1 = 1'($urandom);
                w0 = 1'($urandom); w1 = 1'($urandom);
                addr0 = 16'($urandom); addr1 = 16'($urandom);
                wdata0 = 16'($urandom); wdata1 = 16'($urandom);
            end
            dbus_in = (k == wc) ? din : 16'($urandom);
            if (k == wc && rs)
                rdata_m = dbus_in;
            @(negedge clock);
        end
    endtask

    task automatic rand_txn(input bit scr);
        txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            pick_addr(), pick_addr(), 16'($urandom), 16'($urandom),
            16'($urandom), scr);
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 0; req1 = 0; w0 = 0; w1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        dbus_in = 0;
        dsel = 0; wc = 1;
        last_m = 1; rdata_m = 16'h0000;
        repeat (2) @(negedge clock);
        check_reset("rst");
        reset_n = 1'b1;

        // one wait state: read, write, decode miss, contention
        txn(1, 0, 0, 0, RD_A, 16'h0, 16'h0, 16'h0, 16'hE3E3, 0);
        txn(0, 1, 0, 1, 16'h0, WR_A, 16'h0, 16'h71F0, 16'h5A5A, 0);
        txn(1, 0, 0, 0, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h1234, 0);
        for (int i = 0; i < 4; i++)
            txn(1, 1, 0, 1, RD_A, WR_A, 16'hAAAA, 16'h5555,
                16'(16'h0100 + i), 0);
        for (int i = 0; i < 60; i++)
            rand_txn(i[0]);

        // switch to the three-wait-state instance
        reset_n = 1'b0;
        req0 = 0; req1 = 0;
        #1 check_reset("rst_a");
        dsel = 1; wc = 3;
        #1 check_reset("rst_b");
        @(negedge clock);
        reset_n = 1'b1;
        last_m = 1; rdata_m = 16'h0000;

        // inputs scrambled after grant must not disturb the transfer
        txn(1, 0, 0, 0, RD_A, 16'h0, 16'h0, 16'h0, 16'hBEEF, 1);
        for (int i = 0; i < 30; i++)
            rand_txn(1);

        // reset in the middle of a wait phase
        req0 = 1; req1 = 0; w0 = 0; addr0 = RD_A;
        @(negedge clock);
        @(negedge clock);
        check("mid.gnt", 32'({o_gnt1, o_gnt0}), 32'd1);
        reset_n = 1'b0;
        #1 check_reset("rst_mid");
        @(negedge clock);
        req0 = 0;
        reset_n = 1'b1;
        last_m = 1; rdata_m = 16'h0000;
        @(negedge clock);
        check_idle("post_rst");
        txn(1, 1, 1, 0, WR_A, RD_A, 16'hC0DE, 16'h0, 16'h7777, 0);
        for (int i = 0; i < 10; i++)
            rand_txn(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, 1, data-phase wait states (1..15).
REQ-002 SHALL have parameter: RD_ADDR, 16'hFFF0, address of read device.
REQ-003 SHALL have parameter: WR_ADDR, 16'hFFF8, address of write device.
REQ-004 SHALL have port: clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: req0/req1  in  1  bus request from master 0/1.
REQ-007 SHALL have ports: w0/w1  in  1  master 0/1 direction, 1=write, 0=read.
REQ-008 SHALL have ports: addr0/addr1  in  16  master 0/1 address.
REQ-009 SHALL have ports: wdata0/wdata1  in  16  master 0/1 write data.
REQ-010 SHALL have ports: gnt0/gnt1  out  1  grant to master 0/1.
REQ-011 SHALL have ports: ack  out  1  one-cycle completion pulse to granted master.
REQ-012 SHALL have ports: err  out  1  qualifies ack; 1 = no device decoded.
REQ-013 SHALL have ports: rdata  out  16  read data, valid while ack=1.
REQ-014 SHALL have ports: abus  out  16  shared address bus.
REQ-015 SHALL have ports: w  out  1  shared bus direction.
REQ-016 SHALL have ports: dbus_out  out  16 / dbus_oe  out  1  write data and its drive enable (tristate outside this block).
REQ-017 SHALL have ports: dbus_in  in  16  data returned by devices.
REQ-018 SHALL have ports: rd_sel/wd_sel  out  1  device selects.

Function
REQ-019 SHALL implement states IDLE, ADDR, WAIT, DONE.
REQ-020 In IDLE with any req high, SHALL register the winner, go to ADDR; no req -> stay IDLE.
REQ-021 Arbitration SHALL be round-robin: sole requester wins; both requesting -> master not last granted wins; last-granted pointer resets to master 1 (master 0 wins first tie).
REQ-022 Exactly one gnt SHALL be high in ADDR, WAIT, DONE; both low in IDLE.
REQ-023 In ADDR, abus and w SHALL carry the winner's addr/w (registered at grant); decode SHALL set rd_sel = (w=0 and abus=RD_ADDR), wd_sel = (w=1 and abus=WR_ADDR).
REQ-024 abus, w, sel SHALL hold stable from ADDR through DONE; dbus_oe=1 and dbus_out=winner's wdata in ADDR..DONE only for writes.
REQ-025 WAIT SHALL last exactly WAIT_CYCLES cycles (4-bit down counter), then DONE.
REQ-026 On the last WAIT cycle, reads SHALL capture dbus_in into rdata.
REQ-027 DONE SHALL last one cycle with ack=1, err = (rd_sel|wd_sel)==0, then IDLE.
REQ-028 Latency: req sampled in IDLE at edge N -> ack high in cycle N+2+WAIT_CYCLES; back-to-back grant no earlier than one IDLE cycle later.
REQ-029 req deassertion after grant SHALL NOT abort; transaction completes.
REQ-030 Master's addr/w/wdata SHALL be sampled only at grant; later changes ignored.
REQ-031 rdata SHALL hold last captured value until next read capture; err read -> rdata unchanged.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, gnt0/1=0, ack=0, err=0, abus=0, w=0, dbus_oe=0, dbus_out=0, rd_sel=wd_sel=0, rdata=0, counter=0, pointer=master 1.
REQ-033 Reset mid-transaction SHALL drop it without ack; first cycle after release is IDLE.

Structure
REQ-034 State encoding and RD_ADDR/WR_ADDR defaults SHALL live in shared package bus_pkg.
REQ-035 Round-robin SHALL be one sub-module rr_arb2 (req[1:0], update -> gnt[1:0]); FSM/datapath in bus_arbiter.

Verification
REQ-036 Reset: reset_n=0 mid-WAIT -> all outputs 0 same cycle, IDLE after release.
REQ-037 Read: req0, w0=0, addr0=FFF0, dbus_in=E3E3, WAIT_CYCLES=1 -> gnt0, rd_sel=1, ack 3 cycles after req sampled, err=0, rdata=E3E3.
REQ-038 Write: req1, w1=1, addr1=FFF8, wdata1=71F0 -> wd_sel=1, dbus_oe=1, dbus_out=71F0 ADDR..DONE, ack, err=0.
REQ-039 Contention: req0 and req1 held high -> grants alternate 0,1,0,1 over four transactions.
REQ-040 Decode miss: read addr 0000 -> ack=1, err=1, rd_sel=wd_sel=0, rdata unchanged.
REQ-041 Stability: change addr0 and drop req0 during WAIT (WAIT_CYCLES=3) -> abus unchanged, ack still after 3 WAIT cycles.
